// File: rtl/pipelined_prefix_adder.sv
// Pipelined Ladner-Fischer prefix adder/subtractor with a valid/ready stream interface and a tag sideband.
// Optional signed saturation is compiled in when PIPELINED_PREFIX_ADDER_SAT_EN is defined.
module pipelined_prefix_adder #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   input  logic             sat,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int K = $clog2(WIDTH);

   // Handshake: a stage moves only when the output register is empty or being drained.
   // in_ready = advance & !rst; a transfer happens on a rising edge where in_valid & in_ready.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !rst;

   logic [K:0]       stg_valid;
   logic [WIDTH-1:0] stg_g   [0:K];
   logic [WIDTH-1:0] stg_p   [0:K];
   logic [WIDTH-1:0] stg_h   [0:K];
   logic [TAG_W-1:0] stg_tag [0:K];
   logic [K:0]       stg_cin;
   logic [K:0]       stg_a_msb;
   logic [K:0]       stg_b_msb;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
   logic [K:0]       stg_sat;
`else
   logic             unused_sat;
   assign unused_sat = sat;
`endif

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] g0;
   logic [WIDTH-1:0] p0;
   logic             cin_eff;

   // Carry-in is folded into bit 0's generate so the prefix tree stays WIDTH bits wide.
   always_comb begin
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? 1'b1 : c_in;
      p0      = a ^ b_eff;
      g0      = a & b_eff;
      g0[0]   = g0[0] | (p0[0] & cin_eff);
   end

   logic [WIDTH-1:0] lvl_g [1:K];
   logic [WIDTH-1:0] lvl_p [1:K];

   // Level k: bits in the upper half of each 2^k block absorb the top bit of the lower half.
   always_comb begin
      for (int k = 1; k <= K; k++) begin
         lvl_g[k] = stg_g[k-1];
         lvl_p[k] = stg_p[k-1];
         for (int i = 0; i < WIDTH; i++) begin
            if (((i >> (k - 1)) & 1) == 1) begin
               int j;
               j = ((i >> k) << k) + (1 << (k - 1)) - 1;
               lvl_g[k][i] = stg_g[k-1][i] | (stg_p[k-1][i] & stg_g[k-1][j]);
               lvl_p[k][i] = stg_p[k-1][i] & stg_p[k-1][j];
            end
         end
      end
   end

   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] fin_sum;
   logic             raw_cout;
   logic             raw_ovf;

   always_comb begin
      carry    = {stg_g[K][WIDTH-2:0], stg_cin[K]};
      raw_sum  = stg_h[K] ^ carry;
      raw_cout = stg_g[K][WIDTH-1];
      raw_ovf  = (stg_a_msb[K] == stg_b_msb[K]) && (raw_sum[WIDTH-1] != stg_a_msb[K]);
      fin_sum  = raw_sum;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
      if (stg_sat[K] && raw_ovf)
         fin_sum = stg_a_msb[K] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         out_tag   <= '0;
      end else if (advance) begin
         stg_valid <= {stg_valid[K-1:0], in_valid};
         out_valid <= stg_valid[K];
         if (stg_valid[K]) begin
            sum     <= fin_sum;
            c_out   <= raw_cout;
            ovf     <= raw_ovf;
            out_tag <= stg_tag[K];
         end
      end
   end

   // Datapath registers carry no reset; their contents only matter under a set valid bit.
   always_ff @(posedge clk) begin
      if (advance) begin
         stg_g[0]   <= g0;
         stg_p[0]   <= p0;
         stg_h[0]   <= p0;
         stg_tag[0] <= in_tag;
         for (int k = 1; k <= K; k++) begin
            stg_g[k]   <= lvl_g[k];
            stg_p[k]   <= lvl_p[k];
            stg_h[k]   <= stg_h[k-1];
            stg_tag[k] <= stg_tag[k-1];
         end
         stg_cin   <= {stg_cin[K-1:0], cin_eff};
         stg_a_msb <= {stg_a_msb[K-1:0], a[WIDTH-1]};
         stg_b_msb <= {stg_b_msb[K-1:0], b_eff[WIDTH-1]};
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
         stg_sat   <= {stg_sat[K-1:0], sat};
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder: WIDTH=16 main instance plus WIDTH=64 and WIDTH=4 instances.
// Expected results come from an integer-arithmetic model and hand-computed literals.
module tb_pipelined_prefix_adder;

   localparam int W    = 16;
   localparam int EW   = W + 6;
   localparam int EW64 = 64 + 6;
   localparam int EW4  = 4 + 6;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic         in_valid, in_ready, c_in, sub, sat, out_valid, out_ready, c_out, ovf;
   logic [W-1:0] a, b, sum;
   logic [3:0]   in_tag, out_tag;

   pipelined_prefix_adder #(.WIDTH(W), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .c_in(c_in), .sub(sub), .sat(sat), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .out_tag(out_tag));

   // ---------------- wide / narrow instances ----------------
   logic         x_out_ready;
   logic         x64_in_valid, x64_in_ready, x64_c_in, x64_sub, x64_sat, x64_out_valid, x64_c_out, x64_ovf;
   logic [63:0]  x64_a, x64_b, x64_sum;
   logic [3:0]   x64_in_tag, x64_out_tag;
   logic         x4_in_valid, x4_in_ready, x4_c_in, x4_sub, x4_sat, x4_out_valid, x4_c_out, x4_ovf;
   logic [3:0]   x4_a, x4_b, x4_sum;
   logic [3:0]   x4_in_tag, x4_out_tag;

   pipelined_prefix_adder #(.WIDTH(64), .TAG_W(4)) dut64 (
      .clk(clk), .rst(rst), .in_valid(x64_in_valid), .in_ready(x64_in_ready), .a(x64_a), .b(x64_b),
      .c_in(x64_c_in), .sub(x64_sub), .sat(x64_sat), .in_tag(x64_in_tag), .out_valid(x64_out_valid),
      .out_ready(x_out_ready), .sum(x64_sum), .c_out(x64_c_out), .ovf(x64_ovf), .out_tag(x64_out_tag));

   pipelined_prefix_adder #(.WIDTH(4), .TAG_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(x4_in_valid), .in_ready(x4_in_ready), .a(x4_a), .b(x4_b),
      .c_in(x4_c_in), .sub(x4_sub), .sat(x4_sat), .in_tag(x4_in_tag), .out_valid(x4_out_valid),
      .out_ready(x_out_ready), .sum(x4_sum), .c_out(x4_c_out), .ovf(x4_ovf), .out_tag(x4_out_tag));

   // ---------------- bookkeeping ----------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Returns {ovf, c_out, sum[63:0]} for a w-bit operation using plain integer addition.
   function automatic logic [65:0] model(input int w, input logic [63:0] a_, input logic [63:0] b_,
                                         input logic cin_, input logic sub_, input logic sat_);
      logic [63:0] mask, bb, raw, res;
      logic [64:0] full;
      logic        ci, sa, sb, sr, co, ov;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bb   = sub_ ? (~b_ & mask) : (b_ & mask);
      ci   = sub_ ? 1'b1 : cin_;
      full = {1'b0, a_ & mask} + {1'b0, bb} + {64'd0, ci};
      raw  = full[63:0] & mask;
      co   = full[w];
      sa   = a_[w-1];
      sb   = bb[w-1];
      sr   = raw[w-1];
      ov   = (sa == sb) && (sr != sa);
      res  = raw;
      if (SAT_EN && sat_ && ov) res = sa ? (64'd1 << (w - 1)) : (mask >> 1);
      return {ov, co, res};
   endfunction

   function automatic logic [EW-1:0] exp16(input logic [15:0] a_, input logic [15:0] b_, input logic cin_,
                                           input logic sub_, input logic sat_, input logic [3:0] tag_);
      logic [65:0] m;
      m = model(16, {48'd0, a_}, {48'd0, b_}, cin_, sub_, sat_);
      return {tag_, m[65], m[64], m[15:0]};
   endfunction

   function automatic logic [EW64-1:0] exp64(input logic [63:0] a_, input logic [63:0] b_, input logic cin_,
                                             input logic sub_, input logic sat_, input logic [3:0] tag_);
      logic [65:0] m;
      m = model(64, a_, b_, cin_, sub_, sat_);
      return {tag_, m[65], m[64], m[63:0]};
   endfunction

   function automatic logic [EW4-1:0] exp4(input logic [3:0] a_, input logic [3:0] b_, input logic cin_,
                                           input logic sub_, input logic sat_, input logic [3:0] tag_);
      logic [65:0] m;
      m = model(4, {60'd0, a_}, {60'd0, b_}, cin_, sub_, sat_);
      return {tag_, m[65], m[64], m[3:0]};
   endfunction

   // ---------------- scoreboards ----------------
   logic [EW-1:0]   exp_q[$];
   logic [EW64-1:0] q64[$];
   logic [EW4-1:0]  q4[$];
   logic            held = 1'b0;
   logic [EW-1:0]   held_val;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         held = 1'b0;
         check("rst_in_ready", in_ready, 0);
      end else begin
         check("in_ready_advance", in_ready, (!out_valid || out_ready));
         if (held) check("hold_stable", {out_valid, out_tag, ovf, c_out, sum}, {1'b1, held_val});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL stale_output: got sum=%0h tag=%0h, required no output", sum, out_tag);
            end else begin
               check("result", {out_tag, ovf, c_out, sum}, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(exp16(a, b, c_in, sub, sat, in_tag));
         held     = out_valid && !out_ready;
         held_val = {out_tag, ovf, c_out, sum};
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q64.delete();
         q4.delete();
      end else begin
         if (x64_out_valid) begin
            if (q64.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL w64_stale: got sum=%0h, required no output", x64_sum);
            end else begin
               check("w64_result", {x64_out_tag, x64_ovf, x64_c_out, x64_sum}, q64[0]);
               if (x_out_ready) void'(q64.pop_front());
            end
         end
         if (x64_in_valid && x64_in_ready) q64.push_back(exp64(x64_a, x64_b, x64_c_in, x64_sub, x64_sat, x64_in_tag));
         if (x4_out_valid) begin
            if (q4.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL w4_stale: got sum=%0h, required no output", x4_sum);
            end else begin
               check("w4_result", {x4_out_tag, x4_ovf, x4_c_out, x4_sum}, q4[0]);
               if (x_out_ready) void'(q4.pop_front());
            end
         end
         if (x4_in_valid && x4_in_ready) q4.push_back(exp4(x4_a, x4_b, x4_c_in, x4_sub, x4_sat, x4_in_tag));
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the edge that took the item.
   task automatic send(input logic [15:0] a_, input logic [15:0] b_, input logic cin_, input logic sub_,
                       input logic sat_, input logic [3:0] tag_);
      int guard;
      a = a_; b = b_; c_in = cin_; sub = sub_; sat = sat_; in_tag = tag_;
      in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [15:0] es, input logic ec, input logic eo,
                             input logic [3:0] et, output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, lat);
      end else begin
         check({name, "_sum"}, sum, es);
         check({name, "_c_out"}, c_out, ec);
         check({name, "_ovf"}, ovf, eo);
         check({name, "_tag"}, out_tag, et);
      end
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      check(name, exp_q.size(), 0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic stream_done;
   int   lat, lat64, lat4;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; sat = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      x_out_ready = 1'b1;
      x64_in_valid = 1'b0; x64_a = '0; x64_b = '0; x64_c_in = 1'b0; x64_sub = 1'b0; x64_sat = 1'b0; x64_in_tag = '0;
      x4_in_valid = 1'b0; x4_a = '0; x4_b = '0; x4_c_in = 1'b0; x4_sub = 1'b0; x4_sat = 1'b0; x4_in_tag = '0;

      @(negedge clk);
      check("reset_state", {out_valid, sum, c_out, ovf, out_tag}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // model pinned against hand-computed values
      check("pin_add_wrap", model(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 1'b0), {1'b0, 1'b1, 64'h0});
      check("pin_pos_ovf", model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b1),
            {1'b1, 1'b0, (SAT_EN ? 64'h7FFF : 64'h8000)});
      check("pin_sub_borrow", model(16, 64'h0005, 64'h0007, 1'b0, 1'b1, 1'b0), {1'b0, 1'b0, 64'hFFFE});
      check("pin_sub_ovf", model(16, 64'h8000, 64'h0001, 1'b0, 1'b1, 1'b0), {1'b1, 1'b1, 64'h7FFF});

      // directed single operations
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h3);
      expect_out("t1", 16'h0000, 1'b1, 1'b0, 4'h3, lat);
      check("t1_latency", lat, 6);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 4'h5);
      expect_out("t2_pos", SAT_EN ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 4'h5, lat);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 4'h6);
      expect_out("t2_neg", SAT_EN ? 16'h8000 : 16'h0000, 1'b1, 1'b1, 4'h6, lat);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 4'h7);
      expect_out("t3_borrow", 16'hFFFE, 1'b0, 1'b0, 4'h7, lat);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 4'h8);
      expect_out("t3_ovf", 16'h7FFF, 1'b1, 1'b1, 4'h8, lat);
      send(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h9);
      expect_out("cin_add", 16'h0100, 1'b0, 1'b0, 4'h9, lat);
      send(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, 4'hB);
      expect_out("sub_ign_cin", 16'h0000, 1'b1, 1'b0, 4'hB, lat);

      // random stream with random backpressure
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain("t4_drained");

      // fill with the consumer stalled
      out_ready = 1'b0;
      for (int j = 1; j <= 6; j++) send(16'(j << 12), 16'h0234, 1'b0, 1'b0, 1'b0, 4'(9 + j));
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t5_in_ready", in_ready, 0);
         check("t5_out_valid", out_valid, 1);
         check("t5_first_sum", sum, 16'h1234);
         check("t5_first_tag", out_tag, 4'hA);
      end
      @(posedge clk); #1;
      drain("t5_drained");

      // reset with four items in flight
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++)
         send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0, 1'b0, 1'b0, 4'(j));
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; sat = 1'b0; in_tag = 4'hC;
      in_valid = 1'b1;
      @(negedge clk);
      check("t6_out_valid", out_valid, 0);
      check("t6_sum", sum, 0);
      check("t6_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_out("t6_new", 16'h3333, 1'b0, 1'b0, 4'hC, lat);
      check("t6_latency", lat, 6);
      repeat (10) begin @(posedge clk); #1; end
      check("t6_drained", exp_q.size(), 0);

      // WIDTH=64 and WIDTH=4: wrap-around case and latency K+2
      x64_a = '1; x64_b = 64'd1; x64_c_in = 1'b0; x64_sub = 1'b0; x64_sat = 1'b0; x64_in_tag = 4'h3;
      x4_a = 4'hF; x4_b = 4'h1; x4_c_in = 1'b0; x4_sub = 1'b0; x4_sat = 1'b0; x4_in_tag = 4'h3;
      x64_in_valid = 1'b1;
      x4_in_valid = 1'b1;
      @(negedge clk);
      check("w64_in_ready", x64_in_ready, 1);
      check("w4_in_ready", x4_in_ready, 1);
      @(posedge clk); #1;
      x64_in_valid = 1'b0;
      x4_in_valid = 1'b0;
      lat64 = 0;
      lat4 = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (x64_out_valid && lat64 == 0) begin
            lat64 = c;
            check("w64_t1", {x64_out_tag, x64_ovf, x64_c_out, x64_sum}, {4'h3, 1'b0, 1'b1, 64'h0});
         end
         if (x4_out_valid && lat4 == 0) begin
            lat4 = c;
            check("w4_t1", {x4_out_tag, x4_ovf, x4_c_out, x4_sum}, {4'h3, 1'b0, 1'b1, 4'h0});
         end
      end
      check("w64_latency", lat64, 8);
      check("w4_latency", lat4, 4);
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         x64_a = {$urandom, $urandom}; x64_b = {$urandom, $urandom};
         x64_c_in = 1'($urandom_range(0, 1)); x64_sub = 1'($urandom_range(0, 1));
         x64_sat = 1'($urandom_range(0, 1)); x64_in_tag = 4'(i);
         x4_a = 4'($urandom_range(0, 15)); x4_b = 4'($urandom_range(0, 15));
         x4_c_in = 1'($urandom_range(0, 1)); x4_sub = 1'($urandom_range(0, 1));
         x4_sat = 1'($urandom_range(0, 1)); x4_in_tag = 4'(i);
         x64_in_valid = 1'b1;
         x4_in_valid = 1'b1;
         @(posedge clk); #1;
      end
      x64_in_valid = 1'b0;
      x4_in_valid = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      check("w64_drained", q64.size(), 0);
      check("w4_drained", q4.size(), 0);
      check("main_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
